// File: rtl/preg_free_alloc_if.sv
// Rename/commit handshake bundle for the physical-register free-list allocator.
// master = rename and commit side, slave = allocator.
interface preg_free_alloc_if #(
  parameter int NPREG = 64,
  parameter int WIDTH = $clog2(NPREG)
);
  logic             i_req;
  logic             o_ack;
  logic             o_valid;
  logic [WIDTH-1:0] o_tag;
  logic             i_free0_en;
  logic [WIDTH-1:0] i_free0_tag;
  logic             i_free1_en;
  logic [WIDTH-1:0] i_free1_tag;
  logic             i_ckpt;
  logic             i_restore;
  logic [WIDTH:0]   o_count;
  logic             o_err;

  modport master (
    output i_req, i_free0_en, i_free0_tag, i_free1_en, i_free1_tag, i_ckpt, i_restore,
    input  o_ack, o_valid, o_tag, o_count, o_err
  );

  modport slave (
    input  i_req, i_free0_en, i_free0_tag, i_free1_en, i_free1_tag, i_ckpt, i_restore,
    output o_ack, o_valid, o_tag, o_count, o_err
  );
endinterface

// File: rtl/preg_free_alloc.sv
// Free-list bitmap allocator: one highest-index tag per cycle, same-cycle grant, two frees, one checkpoint.
// Grant is combinational (o_ack); no backpressure beyond an empty list or a restore cycle.
module preg_free_alloc #(
  parameter int NPREG = 64,
  parameter int NAREG = 32,
  parameter int WIDTH = $clog2(NPREG)
) (
  input logic          i_clk,
  input logic          i_rst,
  preg_free_alloc_if.slave bus
);
  localparam logic [NPREG-1:0] RST_BM = {{(NPREG-NAREG){1'b1}}, {NAREG{1'b0}}};

  logic [NPREG-1:0] bm, bm_n;
  logic [NPREG-1:0] ckpt, ckpt_n;
  logic [NPREG-1:0] free_bits, alloc_bit;
  logic [WIDTH:0]   count, count_n;
  logic             err, err_n;
  logic [WIDTH-1:0] top_tag;
  logic             valid, ack;
  logic             f0_live, f1_live;

  // Ascending scan so the last hit, i.e. the highest free index, wins.
  always_comb begin
    top_tag = '0;
    for (int i = 0; i < NPREG; i++) begin
      if (bm[i]) top_tag = WIDTH'(i);
    end
  end

  assign valid = |bm;
  assign ack   = bus.i_req & valid & ~bus.i_restore;

  assign f0_live = bus.i_free0_en && (bus.i_free0_tag != '0);
  assign f1_live = bus.i_free1_en && (bus.i_free1_tag != '0);

  always_comb begin
    free_bits = '0;
    if (f0_live) free_bits[bus.i_free0_tag] = 1'b1;
    if (f1_live) free_bits[bus.i_free1_tag] = 1'b1;
  end

  always_comb begin
    alloc_bit = '0;
    if (ack) alloc_bit[top_tag] = 1'b1;
  end

  // Frees are folded into the checkpoint every cycle so a restore never loses committed returns.
  always_comb begin
    if (bus.i_restore) bm_n = ckpt | free_bits;
    else               bm_n = (bm & ~alloc_bit) | free_bits;
    if (bus.i_ckpt)    ckpt_n = bm_n;
    else               ckpt_n = ckpt | free_bits;
  end

  always_comb begin
    count_n = '0;
    for (int i = 0; i < NPREG; i++) begin
      count_n = count_n + {{WIDTH{1'b0}}, bm_n[i]};
    end
  end

  // Freeing a tag that is already free (including this cycle's grant) or the same tag twice is a double free.
  always_comb begin
    err_n = err;
    if (f0_live && bm[bus.i_free0_tag]) err_n = 1'b1;
    if (f1_live && bm[bus.i_free1_tag]) err_n = 1'b1;
    if (f0_live && f1_live && (bus.i_free0_tag == bus.i_free1_tag)) err_n = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bm    <= RST_BM;
      ckpt  <= RST_BM;
      count <= (WIDTH+1)'(NPREG - NAREG);
      err   <= 1'b0;
    end else begin
      bm    <= bm_n;
      ckpt  <= ckpt_n;
      count <= count_n;
      err   <= err_n;
    end
  end

  assign bus.o_valid = valid;
  assign bus.o_tag   = top_tag;
  assign bus.o_ack   = ack;
  assign bus.o_count = count;
  assign bus.o_err   = err;
endmodule

// File: tb/tb_preg_free_alloc.sv
// Scoreboard bench for preg_free_alloc: directed test-plan scenarios followed by random traffic.
module tb_preg_free_alloc;
  localparam int NP = 64;
  localparam int NA = 32;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  preg_free_alloc_if #(.NPREG(NP)) bus();

  preg_free_alloc #(.NPREG(NP), .NAREG(NA)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  typedef struct {
    bit       vld;
    bit [5:0] tag;
    bit       ack;
    int       cnt;
    bit       err;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: a set of free tags as a bit array, plus a saved copy.
  bit mfree[NP];
  bit mckpt[NP];
  int mcount;
  bit merr;

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) begin
      mfree[i] = (i >= NA);
      mckpt[i] = (i >= NA);
    end
    mcount = NP - NA;
    merr   = 1'b0;
  endfunction

  task automatic step(input bit req, input bit f0e, input int f0t, input bit f1e, input int f1t,
                      input bit ck, input bit rs, input bit rst, input bit push);
    exp_t e;
    bit   nf[NP];
    @(posedge i_clk);
    #1;
    bus.i_req       = req;
    bus.i_free0_en  = f0e;
    bus.i_free0_tag = 6'(f0t);
    bus.i_free1_en  = f1e;
    bus.i_free1_tag = 6'(f1t);
    bus.i_ckpt      = ck;
    bus.i_restore   = rs;
    i_rst           = rst;
    e.vld = 1'b0;
    e.tag = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (mfree[i] && !e.vld) begin
        e.vld = 1'b1;
        e.tag = 6'(i);
      end
    end
    e.ack = req && e.vld && !rs;
    e.cnt = mcount;
    e.err = merr;
    if (push) sb_q.push_back(e);
    if (rst) begin
      model_reset();
    end else begin
      if (f0e && f0t != 0 && mfree[f0t]) merr = 1'b1;
      if (f1e && f1t != 0 && mfree[f1t]) merr = 1'b1;
      if (f0e && f1e && f0t == f1t && f0t != 0) merr = 1'b1;
      nf = mfree;
      if (rs) nf = mckpt;
      else if (e.ack) nf[e.tag] = 1'b0;
      if (f0e && f0t != 0) begin nf[f0t] = 1'b1; mckpt[f0t] = 1'b1; end
      if (f1e && f1t != 0) begin nf[f1t] = 1'b1; mckpt[f1t] = 1'b1; end
      if (ck) mckpt = nf;
      mfree  = nf;
      mcount = 0;
      for (int i = 0; i < NP; i++) mcount += int'(mfree[i]);
    end
    #1;
  endtask

  task automatic idle();       step(0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic alloc();      step(1, 0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic do_reset();   step(0, 0, 0, 0, 0, 0, 0, 1, 1); endtask
  task automatic free1(input int t); step(0, 1, t, 0, 0, 0, 0, 0, 1); endtask

  task automatic chk(input string name, input logic [31:0] act, input int exp_v);
    if (act !== 32'(exp_v)) begin
      $display("FAIL %s got %0d want %0d", name, act, exp_v);
      miscompares++;
    end
  endtask

  function automatic int pick_tag();
    int r;
    if ($urandom_range(0, 3) != 0) begin
      for (int k = 0; k < 8; k++) begin
        r = int'($urandom_range(1, NP - 1));
        if (!mfree[r]) return r;
      end
    end
    return int'($urandom_range(0, NP - 1));
  endfunction

  always @(negedge i_clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      if (bus.o_valid !== e.vld) begin
        $display("FAIL valid got %0b want %0b at %0t", bus.o_valid, e.vld, $time);
        miscompares++;
      end
      if (e.vld && bus.o_tag !== e.tag) begin
        $display("FAIL tag got %0d want %0d at %0t", bus.o_tag, e.tag, $time);
        miscompares++;
      end
      if (bus.o_ack !== e.ack) begin
        $display("FAIL ack got %0b want %0b at %0t", bus.o_ack, e.ack, $time);
        miscompares++;
      end
      if (bus.o_count !== 7'(e.cnt)) begin
        $display("FAIL count got %0d want %0d at %0t", bus.o_count, e.cnt, $time);
        miscompares++;
      end
      if (bus.o_err !== e.err) begin
        $display("FAIL err got %0b want %0b at %0t", bus.o_err, e.err, $time);
        miscompares++;
      end
    end
  end

  initial begin
    int n;
    bus.i_req = 0; bus.i_free0_en = 0; bus.i_free0_tag = '0; bus.i_free1_en = 0;
    bus.i_free1_tag = '0; bus.i_ckpt = 0; bus.i_restore = 0; i_rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Three grants from reset: 63, 62, 61.
    idle();
    chk("rst_tag", bus.o_tag, 63);
    chk("rst_cnt", bus.o_count, 32);
    chk("rst_err", bus.o_err, 0);
    repeat (3) alloc();
    idle();
    chk("alloc3_tag", bus.o_tag, 60);
    chk("alloc3_cnt", bus.o_count, 29);

    // Drain to empty, then refill with tag 40.
    repeat (29) alloc();
    idle();
    chk("empty_vld", bus.o_valid, 0);
    chk("empty_cnt", bus.o_count, 0);
    alloc();
    chk("empty_ack", bus.o_ack, 0);
    free1(40);
    idle();
    chk("refill_vld", bus.o_valid, 1);
    chk("refill_tag", bus.o_tag, 40);

    // Dual-port free, then a tag-0 free.
    do_reset();
    alloc();
    step(0, 1, 63, 1, 10, 0, 0, 0, 1);
    idle();
    chk("dual_tag", bus.o_tag, 63);
    chk("dual_cnt", bus.o_count, 33);
    free1(0);
    idle();
    chk("zero_cnt", bus.o_count, 33);
    chk("zero_err", bus.o_err, 0);

    // Checkpoint, speculative grants with a commit free in flight, restore.
    do_reset();
    step(0, 0, 0, 0, 0, 1, 0, 0, 1);
    alloc();
    step(1, 1, 5, 0, 0, 0, 0, 0, 1);
    alloc();
    alloc();
    step(1, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("restore_ack", bus.o_ack, 0);
    idle();
    chk("restore_tag", bus.o_tag, 63);
    chk("restore_cnt", bus.o_count, 33);

    // Double free of an already-free tag is sticky.
    free1(50);
    idle();
    chk("dbl_err", bus.o_err, 1);
    chk("dbl_cnt", bus.o_count, 33);
    repeat (5) idle();
    chk("dbl_sticky", bus.o_err, 1);

    // Reset in a busy cycle, then prove the checkpoint was reset too.
    step(1, 1, 10, 0, 0, 1, 0, 1, 1);
    idle();
    chk("midrst_tag", bus.o_tag, 63);
    chk("midrst_cnt", bus.o_count, 32);
    chk("midrst_err", bus.o_err, 0);
    alloc();
    alloc();
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle();
    chk("rstckpt_cnt", bus.o_count, 32);
    chk("rstckpt_tag", bus.o_tag, 63);

    for (int c = 0; c < 3000; c++) begin
      bit rq, e0, e1, ck, rs, rt;
      int t0, t1;
      rq = ($urandom_range(0, 9) < 7);
      e0 = ($urandom_range(0, 9) < 4);
      e1 = ($urandom_range(0, 9) < 4);
      t0 = pick_tag();
      t1 = pick_tag();
      ck = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 29) == 0);
      rt = ($urandom_range(0, 99) == 0);
      step(rq, e0, t0, e1, t1, ck, rs, rt, 1);
    end

    idle();
    n = 0;
    while (sb_q.size() > 0 && n < 10) begin
      @(posedge i_clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      $display("FAIL drain got %0d pending want 0", sb_q.size());
      miscompares++;
    end
    @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/preg_free_alloc.md
Name: preg_free_alloc

Overview:
- Physical-register free-list allocator for the rename stage.
- Keeps a free bitmap and hands out one free physical tag per cycle, chosen by priority encoding with the highest free index winning.
- Takes back up to two tags per cycle from commit.
- Holds one checkpoint of the bitmap so branch-mispredict recovery discards speculative allocations.

Parameters:
- NPREG, 64, number of physical registers; tag 0 is the hardwired-zero register and is never allocated or freed.
- NAREG, 32, architectural registers; tags 0..NAREG-1 are mapped at reset.
- WIDTH, $clog2(NPREG), tag width.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset.
- i_req  input  1  rename requests one physical tag this cycle.
- o_ack  output  1  allocation fires this cycle; combinational, equals i_req & o_valid & ~i_restore.
- o_valid  output  1  at least one tag is free (bitmap nonzero); combinational from state.
- o_tag  output  WIDTH  highest-index free tag; combinational from state; meaningful only when o_valid=1.
- i_free0_en  input  1  free port 0 valid.
- i_free0_tag  input  WIDTH  tag returned on port 0.
- i_free1_en  input  1  free port 1 valid.
- i_free1_tag  input  WIDTH  tag returned on port 1.
- i_ckpt  input  1  capture checkpoint.
- i_restore  input  1  restore bitmap from checkpoint.
- o_count  output  WIDTH+1  registered number of free tags.
- o_err  output  1  sticky error flag (double free).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Clock and reset ports are i_clk and i_rst.
- Reset state:
  - Bitmap bits [NAREG-1:0]=0 and [NPREG-1:NAREG]=1; checkpoint = same value.
  - o_count=NPREG-NAREG (32); o_err=0.
  - Therefore o_valid=1 and o_tag=NPREG-1 in the first cycle after reset.
- Next-bitmap computation, in this order:
  - bm_n = bm.
  - If o_ack, clear bit o_tag.
  - Set bit of each enabled free port whose tag != 0.
  - If i_restore, instead bm_n = ckpt OR (this cycle's free bits).
- Timing:
  - Allocation latency: tag valid on o_tag in the same cycle o_ack=1; bit is cleared at the edge.
  - The next cycle presents the next-highest free tag.
  - A freed tag is allocatable from the cycle after the free edge.
- Checkpoint:
  - Every cycle, ckpt_n = ckpt OR (this cycle's free bits). Committed frees are never lost on restore.
  - If i_ckpt, ckpt_n = bm_n instead, so it includes this cycle's alloc and frees.
  - If i_ckpt and i_restore are both high, restore wins for the bitmap and ckpt_n = restored bm_n.
- Free-port rules:
  - Free of tag 0: ignored, with no error.
  - Both ports freeing the same tag in one cycle: bit set once; o_err set.
  - Free of a tag already set in bm: bit stays 1; o_err set next edge.
  - Allocated tag freed in the same cycle: impossible by the rules above, since the allocated tag is free; it is treated as a double free.
- Empty list: o_valid=0, o_ack=0 regardless of i_req; frees that cycle make o_valid=1 next cycle.
- Full list: cannot overflow; excess frees are double frees.
- o_count is registered as popcount(bm_n); it is exact after restore.
- o_err clears only on i_rst.
- Reset mid-operation: all state returns to reset values on the edge; inputs that cycle are ignored.

Test Plan:
- Reset, then i_req=1 for 3 cycles -> o_tag 63, 62, 61 with o_ack=1 each cycle; o_count 32 -> 29.
- Allocate all 32 free tags -> o_valid=0, o_count=0; i_req=1 gives o_ack=0. Free tag 40 -> next cycle o_valid=1, o_tag=40.
- After allocating 63, free 63 and 10 on both ports in one cycle -> next o_tag=63, o_count +2; free tag 0 -> no change, o_err=0.
- Checkpoint at o_count=32, allocate 63..60, free tag 5 meanwhile, then restore:
  - Next cycle o_tag=63, o_count=33, bit 5 free.
  - Same-cycle i_req with the restore gives o_ack=0.
- Free tag 50 while it is free -> o_err=1 and bitmap unchanged; o_err stays 1 until i_rst.
- Assert i_rst during an allocate/free/ckpt cycle -> next cycle o_tag=63, o_count=32, o_err=0, checkpoint at reset value.
